pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline CPU. It decides each cycle whether every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) loads, holds or is flushed. It generates the `EX_Flush` consumed by EX/MEM and the write-enables and flushes for the other stage registers. It handles load-use hazards with a configurable stall length, taken branch/jump redirects resolved in MEM, and a multi-cycle data-memory handshake with a timeout.

## Interface
- `LOAD_STALL_CYCLES`, default 1: bubbles inserted per load-use hazard. Range 1..4; 2 when MEM→EX forwarding is absent.
- `MEM_TIMEOUT`, default 16: maximum frozen cycles per memory access before a forced release. 0 disables the timeout. 8-bit range.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `rs_ID`, `rt_ID` in 5 each: source registers of the instruction in ID.
- `uses_rt_ID` in 1: the ID instruction reads rt.
- `MemRead_EX` in 1: the instruction in EX is a load.
- `rtd_EX` in 5: destination register of the instruction in EX.
- `Branch_MEM`, `Zero_MEM`, `jump_MEM` in 1: branch/jump resolution in MEM.
- `MemRead_MEM`, `MemWrite_MEM` in 1: a data-memory access is in MEM.
- `mem_ack` in 1: data memory completes the access this cycle.
- `PC_Write`, `IF_ID_Write`, `ID_EX_Write`, `EX_MEM_Write` out 1: stage-register load enables.
- `IF_Flush`, `ID_Flush`, `EX_Flush` out 1: zero the control bits entering IF/ID, ID/EX, EX/MEM.
- `MEM_WB_Bubble` out 1: MEM/WB loads a bubble.
- `mem_err` out 1: sticky flag, set on a memory timeout.
- `ctrl_state` out 2: current FSM state.

## Operation
- **States:** RUN=0, LOAD_STALL=1, MEM_WAIT=2. Code 3 is unused and recovers to RUN.
- **Decode terms:**
  - mem_busy = (MemRead_MEM | MemWrite_MEM) & ~mem_ack.
  - taken = (Branch_MEM & Zero_MEM) | jump_MEM.
  - hazard = MemRead_EX & rtd_EX≠0 & (rtd_EX==rs_ID | (uses_rt_ID & rtd_EX==rt_ID)).
- **Outputs** are combinational from the state and inputs. Priority, highest first:
  1. **Freeze** (mem_busy, not released by timeout): all four write enables 0, MEM_WB_Bubble=1, all flushes 0.
  2. **Redirect** (taken): all write enables 1, IF_Flush = ID_Flush = EX_Flush = 1.
  3. **Stall** (state RUN with hazard, or state LOAD_STALL): PC_Write = IF_ID_Write = 0, ID_Flush=1, the other write enables 1.
  4. **Normal:** all write enables 1, all flushes 0, bubble 0.
- **stall_cnt** (3 bits):
  - On a RUN hazard (no freeze, no redirect), stall_cnt loads LOAD_STALL_CYCLES−1. The FSM goes to LOAD_STALL if that value is nonzero, else stays in RUN.
  - In LOAD_STALL, stall_cnt decrements each unfrozen cycle and the FSM returns to RUN on the cycle that stall_cnt==1 decrements to 0.
- **wait_cnt** (8 bits):
  - Freeze in RUN or LOAD_STALL moves the FSM to MEM_WAIT and sets wait_cnt=1. stall_cnt holds.
  - In MEM_WAIT, wait_cnt increments each frozen cycle.
  - **Release** occurs on mem_ack, or when MEM_TIMEOUT≠0 and wait_cnt==MEM_TIMEOUT. The release cycle is unfrozen: normal/stall priority applies.
  - On release, the next state is LOAD_STALL if stall_cnt≠0, else RUN, and wait_cnt clears.
  - A timeout release sets mem_err at the next edge.
- A redirect clears stall_cnt and forces RUN.
- Register 0 never causes a hazard.

## Timing
- While `reset` is low:
  - ctrl_state=RUN, stall_cnt=0, wait_cnt=0, mem_err=0.
  - All write enables, flushes and MEM_WB_Bubble are forced to 0.
  - Statistics counters are 0.
- Reset deasserting mid-stall or mid-wait discards the operation; the FSM restarts in RUN.
- **Load-use stall latency:** a hazard first seen at cycle t holds PC and IF/ID for exactly LOAD_STALL_CYCLES cycles (t .. t+LOAD_STALL_CYCLES−1). The consumer leaves ID at cycle t+LOAD_STALL_CYCLES.
- **Zero-wait access:** mem_ack in the same cycle the access enters MEM causes no freeze.
- **Bounded wait:** frozen cycles per access ≤ MEM_TIMEOUT when MEM_TIMEOUT≠0.
- **Redirect** flushes are one cycle wide, asserted in the cycle taken=1.

## Configuration
- **`PIPE_CTRL_STATS_EN` defined:**
  - Adds outputs `stall_cycles` (16, counts stall-priority cycles) and `flush_events` (16, counts redirect cycles). Both saturate at 16'hFFFF.
  - Both counters are cleared by reset.
- **`PIPE_CTRL_STATS_EN` undefined:** these ports and counters are absent; all other behaviour is identical.

## Test plan
- **Load-use:** MemRead_EX=1, rtd_EX=5, rs_ID=5, LOAD_STALL_CYCLES=2 → PC_Write=0 and ID_Flush=1 for 2 cycles, ctrl_state 0→1→0; with rtd_EX=0 → no stall.
- **Branch:** Branch_MEM=1, Zero_MEM=1 → IF_Flush = ID_Flush = EX_Flush = 1 for one cycle with PC_Write=1. The same with Zero_MEM=0 → no flush.
- **Memory wait:** MemRead_MEM=1, mem_ack asserted after 3 cycles → freeze for 3 cycles with MEM_WB_Bubble=1, then RUN; mem_err stays 0.
- **Timeout:** MEM_TIMEOUT=4, mem_ack never asserted → exactly 4 frozen cycles, then release; mem_err=1 until reset.
- **Simultaneous:** hazard plus mem_busy in the same cycle → freeze wins, and the load-use stall completes after the ack. Also assert reset low during MEM_WAIT → all outputs 0 and ctrl_state=0 immediately.
- **Stats (`PIPE_CTRL_STATS_EN`):** after 3 redirects and 5 stall cycles → flush_events=3, stall_cycles=5.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// PIPE_CTRL_STATS_EN adds the stall_cycles/flush_events statistics signals.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  rs_ID;
    logic [4:0]  rt_ID;
    logic        uses_rt_ID;
    logic        MemRead_EX;
    logic [4:0]  rtd_EX;
    logic        Branch_MEM;
    logic        Zero_MEM;
    logic        jump_MEM;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic        mem_ack;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        ID_EX_Write;
    logic        EX_MEM_Write;
    logic        IF_Flush;
    logic        ID_Flush;
    logic        EX_Flush;
    logic        MEM_WB_Bubble;
    logic        mem_err;
    logic [1:0]  ctrl_state;
`ifdef PIPE_CTRL_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    modport master (
        input  rs_ID, rt_ID, uses_rt_ID, MemRead_EX, rtd_EX,
        input  Branch_MEM, Zero_MEM, jump_MEM,
        input  MemRead_MEM, MemWrite_MEM, mem_ack,
        output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
        output IF_Flush, ID_Flush, EX_Flush, MEM_WB_Bubble,
        output mem_err, ctrl_state
`ifdef PIPE_CTRL_STATS_EN
        , output stall_cycles, flush_events
`endif
    );

    modport slave (
        output rs_ID, rt_ID, uses_rt_ID, MemRead_EX, rtd_EX,
        output Branch_MEM, Zero_MEM, jump_MEM,
        output MemRead_MEM, MemWrite_MEM, mem_ack,
        input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
        input  IF_Flush, ID_Flush, EX_Flush, MEM_WB_Bubble,
        input  mem_err, ctrl_state
`ifdef PIPE_CTRL_STATS_EN
        , input stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, MEM redirects,
// memory-wait freeze with timeout. PIPE_CTRL_STATS_EN enables stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 16
) (
    input logic                    clock,
    input logic                    reset,
    pipeline_hazard_ctrl_if.master hz
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_e;

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_V  = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d, eff_state;
    logic [2:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;
    logic       mem_busy, taken, hazard, timeout_rel, freeze;
    logic       stall_act, stall_out, redirect_out;

    assign mem_busy = (hz.MemRead_MEM | hz.MemWrite_MEM) & ~hz.mem_ack;
    assign taken    = (hz.Branch_MEM & hz.Zero_MEM) | hz.jump_MEM;
    assign hazard   = hz.MemRead_EX && (hz.rtd_EX != 5'd0) &&
                      ((hz.rtd_EX == hz.rs_ID) || (hz.uses_rt_ID && (hz.rtd_EX == hz.rt_ID)));

    assign timeout_rel = (state_q == MEM_WAIT) && (MEM_TIMEOUT != 0) &&
                         (wait_cnt_q == TIMEOUT_V) && mem_busy;
    assign freeze      = mem_busy && !timeout_rel;

    // The release cycle of MEM_WAIT behaves like the state that was interrupted,
    // so a pending or newly seen load-use hazard still stalls there.
    always_comb begin
        case (state_q)
            LOAD_STALL: eff_state = LOAD_STALL;
            MEM_WAIT:   eff_state = (stall_cnt_q != '0) ? LOAD_STALL : RUN;
            default:    eff_state = RUN;
        endcase
    end

    assign stall_act = ((eff_state == RUN) && hazard) || (eff_state == LOAD_STALL);

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q | timeout_rel;
        if (freeze) begin
            if (state_q == MEM_WAIT) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end else begin
                state_d    = MEM_WAIT;
                wait_cnt_d = 8'd1;
            end
        end else begin
            wait_cnt_d = '0;
            state_d    = RUN;
            if (taken) begin
                stall_cnt_d = '0;
            end else if (eff_state == LOAD_STALL) begin
                if (stall_cnt_q != '0) stall_cnt_d = stall_cnt_q - 3'd1;
                if (stall_cnt_q > 3'd1) state_d = LOAD_STALL;
            end else if (hazard) begin
                stall_cnt_d = STALL_INIT;
                if (STALL_INIT != '0) state_d = LOAD_STALL;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign redirect_out = reset && !freeze && taken;
    assign stall_out    = reset && !freeze && !taken && stall_act;

    always_comb begin
        hz.PC_Write      = 1'b0;
        hz.IF_ID_Write   = 1'b0;
        hz.ID_EX_Write   = 1'b0;
        hz.EX_MEM_Write  = 1'b0;
        hz.IF_Flush      = 1'b0;
        hz.ID_Flush      = 1'b0;
        hz.EX_Flush      = 1'b0;
        hz.MEM_WB_Bubble = 1'b0;
        if (reset) begin
            if (freeze) begin
                hz.MEM_WB_Bubble = 1'b1;
            end else begin
                hz.ID_EX_Write  = 1'b1;
                hz.EX_MEM_Write = 1'b1;
                hz.PC_Write     = !stall_out;
                hz.IF_ID_Write  = !stall_out;
                hz.IF_Flush     = redirect_out;
                hz.ID_Flush     = redirect_out || stall_out;
                hz.EX_Flush     = redirect_out;
            end
        end
    end

    assign hz.mem_err    = mem_err_q;
    assign hz.ctrl_state = state_q;

`ifdef PIPE_CTRL_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (stall_out && (stall_cycles_q != '1))    stall_cycles_d = stall_cycles_q + 16'd1;
        if (redirect_out && (flush_events_q != '1)) flush_events_d = flush_events_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
`endif

endmodule
